// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port off-chip memory arbiter.
// Holds the FSM state encoding and small state-classification helpers.
package mem_arb_pkg;

  localparam int WORD_W = 16;
  localparam int BEATS  = 4;
  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_BEAT = 3'd2,
    RD_ACK  = 3'd3,
    WR_ADDR = 3'd4,
    WR_GAP  = 3'd5,
    WR_DATA = 3'd6,
    WR_DONE = 3'd7
  } arb_state_e;

  function automatic logic is_rd_state(input arb_state_e s);
    return (s == RD_ADDR) || (s == RD_BEAT) || (s == RD_ACK);
  endfunction

  function automatic logic is_wr_state(input arb_state_e s);
    return (s == WR_ADDR) || (s == WR_GAP) || (s == WR_DATA) || (s == WR_DONE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_chk.sv
// Structural invariants of the arbiter: grant is one-hot or idle, an idle
// arbiter drives nothing, and an ungranted port never sees a response.
module mem_bus_arbiter_chk #(
  parameter int WORD_W = 16
) (
  input logic              clock,
  input logic              reset,
  input logic [1:0]        gnt,
  input logic              mem_rrqst,
  input logic              mem_wrqst,
  input logic              mem_rdacpt,
  input logic [WORD_W-1:0] mem_offdata,
  input logic [1:0]        rrdy,
  input logic [1:0]        rdrdy,
  input logic [1:0]        wacpt
);

  a_gnt_onehot0: assert property (@(posedge clock) disable iff (reset)
    $onehot0(gnt));

  a_idle_quiet: assert property (@(posedge clock) disable iff (reset)
    (gnt == 2'b00) |-> (!mem_rrqst && !mem_wrqst && !mem_rdacpt &&
                        (mem_offdata == '0) && (rrdy == 2'b00) &&
                        (rdrdy == 2'b00) && (wacpt == 2'b00)));

  a_port0_shielded: assert property (@(posedge clock) disable iff (reset)
    !gnt[0] |-> (!rrdy[0] && !rdrdy[0] && !wacpt[0]));

  a_port1_shielded: assert property (@(posedge clock) disable iff (reset)
    !gnt[1] |-> (!rrdy[1] && !rdrdy[1] && !wacpt[1]));

endmodule

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: the port named by prio wins if it requests,
// otherwise the other port; result is one-hot, zero when nobody requests.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] win
);

  // favoured port first, then the other one
  always_comb begin
    win = 2'b00;
    case (prio)
      1'b0:    win = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
      1'b1:    win = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port between the I- and
// D-cache controllers; a grant is held until its transaction's final handshake.
module mem_bus_arbiter #(
  parameter int WORD_W = mem_arb_pkg::WORD_W,
  parameter int BEATS  = mem_arb_pkg::BEATS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        rrqst,
  input  logic [1:0]        wrqst,
  input  logic [1:0]        rdacpt,
  input  logic [WORD_W-1:0] offdata0,
  input  logic [WORD_W-1:0] offdata1,
  output logic [1:0]        rrdy,
  output logic [1:0]        rdrdy,
  output logic [1:0]        wacpt,
  output logic [1:0]        gnt,
  output logic              mem_rrqst,
  output logic              mem_wrqst,
  output logic              mem_rdacpt,
  output logic [WORD_W-1:0] mem_offdata,
  input  logic              mem_rrdy,
  input  logic              mem_rdrdy,
  input  logic              mem_wacpt
);

  import mem_arb_pkg::*;

  localparam logic [1:0] BEAT_LAST = 2'(BEATS - 1);

  arb_state_e state_r, state_nx_s;
  logic [1:0] gnt_r, gnt_nx_s;
  logic       prio_r, prio_nx_s;
  logic [1:0] beat_r, beat_nx_s;

  logic [1:0] elig_s;
  logic [1:0] win_s;
  logic       gidx_s;
  arb_state_e launch_state_s;
  logic [1:0] launch_gnt_s;
  logic       launch_prio_s;

  assign elig_s = rrqst | wrqst;
  assign gidx_s = gnt_r[1];
  assign gnt    = gnt_r;

  rr_pick2 u_pick (
    .req  (elig_s),
    .prio (prio_r),
    .win  (win_s)
  );

  // Outcome of an arbitration round; used from IDLE and on the releasing
  // edge so a waiting port is granted without an idle bubble.
  always_comb begin
    launch_state_s = IDLE;
    launch_gnt_s   = 2'b00;
    launch_prio_s  = prio_r;
    if (win_s != 2'b00) begin
      launch_gnt_s  = win_s;
      launch_prio_s = ~win_s[1];
      if (rrqst[win_s[1]]) begin
        launch_state_s = RD_ADDR;
      end else begin
        launch_state_s = WR_ADDR;
      end
    end else begin
      launch_state_s = IDLE;
      launch_gnt_s   = 2'b00;
      launch_prio_s  = prio_r;
    end
  end

  // Transaction sequencing, grant/priority update and beat counting
  always_comb begin
    state_nx_s = state_r;
    gnt_nx_s   = gnt_r;
    prio_nx_s  = prio_r;
    beat_nx_s  = beat_r;
    case (state_r)
      IDLE: begin
        state_nx_s = launch_state_s;
        gnt_nx_s   = launch_gnt_s;
        prio_nx_s  = launch_prio_s;
        beat_nx_s  = 2'd0;
      end
      RD_ADDR: begin
        if (mem_rrdy) begin
          state_nx_s = RD_BEAT;
        end else if (!rrqst[gidx_s]) begin
          state_nx_s = IDLE;
          gnt_nx_s   = 2'b00;
        end else begin
          state_nx_s = RD_ADDR;
        end
      end
      RD_BEAT: begin
        if (mem_rdrdy) begin
          state_nx_s = RD_ACK;
        end else begin
          state_nx_s = RD_BEAT;
        end
      end
      RD_ACK: begin
        if (mem_rdrdy) begin
          state_nx_s = RD_ACK;
        end else if (beat_r == BEAT_LAST) begin
          state_nx_s = launch_state_s;
          gnt_nx_s   = launch_gnt_s;
          prio_nx_s  = launch_prio_s;
          beat_nx_s  = 2'd0;
        end else begin
          state_nx_s = RD_BEAT;
          beat_nx_s  = beat_r + 2'd1;
        end
      end
      WR_ADDR: begin
        if (mem_wacpt) begin
          state_nx_s = WR_GAP;
        end else if (!wrqst[gidx_s]) begin
          state_nx_s = IDLE;
          gnt_nx_s   = 2'b00;
        end else begin
          state_nx_s = WR_ADDR;
        end
      end
      WR_GAP: begin
        if (!mem_wacpt) begin
          state_nx_s = WR_DATA;
        end else begin
          state_nx_s = WR_GAP;
        end
      end
      WR_DATA: begin
        if (mem_wacpt) begin
          state_nx_s = WR_DONE;
        end else begin
          state_nx_s = WR_DATA;
        end
      end
      WR_DONE: begin
        if (!mem_wacpt) begin
          state_nx_s = launch_state_s;
          gnt_nx_s   = launch_gnt_s;
          prio_nx_s  = launch_prio_s;
          beat_nx_s  = 2'd0;
        end else begin
          state_nx_s = WR_DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        gnt_nx_s   = 2'b00;
        beat_nx_s  = 2'd0;
      end
    endcase
  end

  // State, grant, priority and beat registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      gnt_r   <= 2'b00;
      prio_r  <= 1'b0;
      beat_r  <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      gnt_r   <= gnt_nx_s;
      prio_r  <= prio_nx_s;
      beat_r  <= beat_nx_s;
    end
  end

  // Forwarding mux; request strobes follow the transaction type chosen at
  // grant so a write asserted alongside a winning read stays invisible.
  always_comb begin
    mem_rrqst   = 1'b0;
    mem_wrqst   = 1'b0;
    mem_rdacpt  = 1'b0;
    mem_offdata = '0;
    rrdy        = 2'b00;
    rdrdy       = 2'b00;
    wacpt       = 2'b00;
    if (gnt_r != 2'b00) begin
      if (is_rd_state(state_r)) begin
        mem_rrqst  = rrqst[gidx_s];
        mem_rdacpt = rdacpt[gidx_s];
      end else if (is_wr_state(state_r)) begin
        mem_wrqst = wrqst[gidx_s];
      end else begin
        mem_rrqst = 1'b0;
        mem_wrqst = 1'b0;
      end
      if (gidx_s == 1'(PORT_D)) begin
        mem_offdata = offdata1;
      end else begin
        mem_offdata = offdata0;
      end
      rrdy[gidx_s]  = mem_rrdy;
      rdrdy[gidx_s] = mem_rdrdy;
      wacpt[gidx_s] = mem_wacpt;
    end else begin
      mem_offdata = '0;
    end
  end

  mem_bus_arbiter_chk #(.WORD_W(WORD_W)) u_chk (
    .clock       (clock),
    .reset       (reset),
    .gnt         (gnt),
    .mem_rrqst   (mem_rrqst),
    .mem_wrqst   (mem_wrqst),
    .mem_rdacpt  (mem_rdacpt),
    .mem_offdata (mem_offdata),
    .rrdy        (rrdy),
    .rdrdy       (rdrdy),
    .wacpt       (wacpt)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: drives both cache ports and the
// memory side, grant order is checked against a scoreboard queue.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  rrqst, wrqst, rdacpt;
  logic [15:0] offdata0, offdata1;
  logic [1:0]  rrdy, rdrdy, wacpt, gnt;
  logic        mem_rrqst, mem_wrqst, mem_rdacpt;
  logic [15:0] mem_offdata;
  logic        mem_rrdy, mem_rdrdy, mem_wacpt;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_gnt = 2'b00;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .rrqst(rrqst), .wrqst(wrqst), .rdacpt(rdacpt),
    .offdata0(offdata0), .offdata1(offdata1),
    .rrdy(rrdy), .rdrdy(rdrdy), .wacpt(wacpt), .gnt(gnt),
    .mem_rrqst(mem_rrqst), .mem_wrqst(mem_wrqst), .mem_rdacpt(mem_rdacpt),
    .mem_offdata(mem_offdata),
    .mem_rrdy(mem_rrdy), .mem_rdrdy(mem_rdrdy), .mem_wacpt(mem_wacpt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Every new grant is popped against the order the stimulus predicted
  always @(negedge clock) begin
    if (!reset && gnt != 2'b00 && gnt != prev_gnt) begin
      if (exp_q.size() == 0) begin
        check_val("gnt_unexpected", gnt, 2'b00);
      end else begin
        check_val("gnt_order", gnt, exp_q.pop_front());
      end
    end
    prev_gnt = gnt;
  end

  task automatic rd_addr(input int p, input bit keep);
    mem_rrdy = 1'b1;
    #1;
    check_val("rrdy_mirror", rrdy[p], 1);
    check_val("rrdy_other", rrdy[1-p], 0);
    check_val("mem_wrqst_rd", mem_wrqst, 0);
    cyc();
    mem_rrdy = 1'b0;
    if (!keep) begin
      rrqst[p] = 1'b0;
      wrqst[p] = 1'b0;
    end
  endtask

  task automatic rd_beat(input int p);
    mem_rdrdy = 1'b1;
    rdacpt[p] = 1'b1;
    #1;
    check_val("rdrdy_mirror", rdrdy[p], 1);
    check_val("rdrdy_other", rdrdy[1-p], 0);
    check_val("rrdy_other_b", rrdy[1-p], 0);
    check_val("mem_rdacpt", mem_rdacpt, 1);
    check_val("mem_wrqst_beat", mem_wrqst, 0);
    cyc();
    mem_rdrdy = 1'b0;
    rdacpt[p] = 1'b0;
    #1;
    check_val("rdrdy_low", rdrdy[p], 0);
    cyc();
  endtask

  task automatic wr_txn(input int p);
    mem_wacpt = 1'b1;
    #1;
    check_val("wacpt_mirror", wacpt[p], 1);
    check_val("wacpt_other", wacpt[1-p], 0);
    check_val("mem_rrqst_wr", mem_rrqst, 0);
    cyc();
    mem_wacpt = 1'b0;
    wrqst[p]  = 1'b0;
    #1;
    check_val("wr_gap_wrqst", mem_wrqst, 0);
    cyc();
    wrqst[p]  = 1'b1;
    mem_wacpt = 1'b1;
    #1;
    check_val("wr_data_wrqst", mem_wrqst, 1);
    check_val("wr_data_wacpt", wacpt[p], 1);
    cyc();
    mem_wacpt = 1'b0;
    wrqst[p]  = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rrqst = 2'b00; wrqst = 2'b00; rdacpt = 2'b00;
    offdata0 = 16'h0000; offdata1 = 16'h0000;
    mem_rrdy = 1'b0; mem_rdrdy = 1'b0; mem_wacpt = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    check_val("rst_gnt", gnt, 2'b00);
    check_val("rst_offdata", mem_offdata, 16'h0000);
    check_val("rst_mem_rq", {mem_rrqst, mem_wrqst, mem_rdacpt}, 3'b000);
    check_val("rst_resp", {rrdy, rdrdy, wacpt}, 6'b000000);

    // port 1 read alone
    offdata1 = 16'h1234;
    rrqst[1] = 1'b1;
    exp_q.push_back(2'b10);
    cyc();
    check_val("p1_gnt", gnt, 2'b10);
    check_val("p1_offdata", mem_offdata, 16'h1234);
    check_val("p1_mem_rrqst", mem_rrqst, 1);
    rd_addr(1, 1'b0);
    for (int b = 0; b < 4; b++) rd_beat(1);
    check_val("p1_release", gnt, 2'b00);

    // simultaneous read on port 0 and write on port 1 from reset priority
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    offdata0 = 16'hABCD;
    rrqst[0] = 1'b1;
    wrqst[1] = 1'b1;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    cyc();
    check_val("sim_gnt0", gnt, 2'b01);
    check_val("sim_offdata0", mem_offdata, 16'hABCD);
    check_val("sim_wacpt1", wacpt[1], 0);
    rd_addr(0, 1'b0);
    for (int b = 0; b < 4; b++) rd_beat(0);
    check_val("sim_no_bubble", gnt, 2'b10);
    check_val("sim_mem_wrqst", mem_wrqst, 1);
    wr_txn(1);
    check_val("sim_release", gnt, 2'b00);

    // continuous contention alternates grants
    rrqst = 2'b11;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    cyc();
    check_val("alt_1", gnt, 2'b01);
    rd_addr(0, 1'b1);
    for (int b = 0; b < 4; b++) rd_beat(0);
    check_val("alt_2", gnt, 2'b10);
    rd_addr(1, 1'b1);
    for (int b = 0; b < 4; b++) rd_beat(1);
    check_val("alt_3", gnt, 2'b01);
    rd_addr(0, 1'b0);
    for (int b = 0; b < 4; b++) rd_beat(0);
    check_val("alt_4", gnt, 2'b10);
    rd_addr(1, 1'b0);
    for (int b = 0; b < 4; b++) rd_beat(1);
    check_val("alt_end", gnt, 2'b00);

    // read and write together on port 0: read runs, write stays hidden
    rrqst[0] = 1'b1;
    wrqst[0] = 1'b1;
    exp_q.push_back(2'b01);
    cyc();
    check_val("rw_gnt", gnt, 2'b01);
    check_val("rw_mem_rrqst", mem_rrqst, 1);
    check_val("rw_mem_wrqst", mem_wrqst, 0);
    rd_addr(0, 1'b0);
    for (int b = 0; b < 4; b++) rd_beat(0);
    check_val("rw_release", gnt, 2'b00);

    // write abort before the memory accepts
    wrqst[0] = 1'b1;
    exp_q.push_back(2'b01);
    cyc();
    check_val("ab_gnt", gnt, 2'b01);
    check_val("ab_mem_wrqst", mem_wrqst, 1);
    wrqst[0] = 1'b0;
    cyc();
    check_val("ab_release", gnt, 2'b00);

    // reset in the middle of a burst, then a fresh full burst
    rrqst[1] = 1'b1;
    exp_q.push_back(2'b10);
    cyc();
    check_val("mr_gnt", gnt, 2'b10);
    rd_addr(1, 1'b1);
    rd_beat(1);
    rd_beat(1);
    mem_rdrdy = 1'b1;
    rdacpt[1] = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    check_val("mr_gnt_rst", gnt, 2'b00);
    check_val("mr_mem_rrqst", mem_rrqst, 0);
    check_val("mr_mem_rdacpt", mem_rdacpt, 0);
    check_val("mr_rdrdy", rdrdy, 2'b00);
    reset = 1'b0;
    mem_rdrdy = 1'b0;
    rdacpt[1] = 1'b0;
    exp_q.push_back(2'b10);
    cyc();
    check_val("mr_regnt", gnt, 2'b10);
    rd_addr(1, 1'b0);
    for (int b = 0; b < 3; b++) rd_beat(1);
    check_val("mr_beat3_held", gnt, 2'b10);
    rd_beat(1);
    check_val("mr_release", gnt, 2'b00);

    cyc();
    cyc();
    check_val("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
